sdio_pixel_assembler: RTL and testbench

//  Sits between the SDIO data-lane front end and the frame buffer/RGB scan-out path.

---
 rtl/sdio_pixel_assembler_pkg.sv | 38 +++
 rtl/sdio_pixel_assembler_sync_fifo.sv | 85 ++++++++
 rtl/sdio_pixel_assembler.sv | 217 +++++++++++++++++++++
 tb/tb_sdio_pixel_assembler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_pixel_assembler_pkg.sv
// -----------------------------------------------------------------------------
// sdio_pixel_assembler_pkg
//
// Purpose:
//   Shared definitions for the SDIO pixel assembler and the scan-out path:
//   pixel format codes, pixel/entry widths, the FIFO entry layout and the
//   RGB565 -> RGB888 expansion helper.
//
// Contents:
//   FMT_565 / FMT_888   format codes carried by the format latch
//   PIX565_W / PIX888_W raw pixel widths in bits
//   RGB_ENTRY_W         width of one FIFO entry {sof, r, g, b}
//   rgb_entry_t         packed view of a FIFO entry
//   rgb565_to_888()     bit-replicating 5:6:5 -> 8:8:8 expansion
// -----------------------------------------------------------------------------
package sdio_pixel_assembler_pkg;

    localparam logic FMT_565 = 1'b0;
    localparam logic FMT_888 = 1'b1;

    localparam int PIX565_W    = 16;
    localparam int PIX888_W    = 24;
    localparam int RGB_ENTRY_W = 25;

    typedef struct packed {
        logic       sof;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_entry_t;

    // Replicating the top bits into the new LSBs maps full-scale 565 values
    // onto full-scale 888 values (1F -> FF, 3F -> FF) and zero onto zero.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/sdio_pixel_assembler_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Purpose:
//   Single-clock first-word-fall-through FIFO with synchronous active-low
//   reset. The head entry is presented directly from storage so a write on
//   one edge is visible at the output right after that edge. Reusable by the
//   scan-out path.
//
// Parameters:
//   WIDTH   entry width in bits
//   DEPTH   number of entries; power of two, >= 2
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (pointers only)
//   push_i   in   write wdata_i; ignored when full unless a pop happens too
//   wdata_i  in   WIDTH  write data
//   pop_i    in   remove the head; ignored when empty
//   rdata_o  out  WIDTH  head entry, forced to 0 while empty
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
//   level_o  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty can be told apart when
    // the address bits match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop on the same edge frees the slot being written, so a push into a
    // full FIFO is accepted in that case (the slot is the current head).
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto RAM; stale
    // contents are never visible because the output is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sdio_pixel_assembler.sv
// -----------------------------------------------------------------------------
// sdio_pixel_assembler
//
// Purpose:
//   Collects BUS_W-bit beats from the SDIO data-lane front end MSB-first into
//   RGB565 or RGB888 pixels, expands them to 8:8:8, buffers complete pixels
//   in a FIFO and hands them on through a valid/ready interface.
//
// Parameters:
//   BUS_W       beat width in bits; 1, 2, 4 or 8
//   FIFO_DEPTH  pixel entries; power of two, >= 2
//
// Ports:
//   clk_pix    in   single clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   beat present on in_data (never back-pressured)
//   in_data    in   BUS_W  beat, MSB-first within the pixel
//   in_sof     in   with in_valid: this beat starts a frame
//   fmt_888    in   format, sampled only with the sof beat (0 = 565, 1 = 888)
//   out_valid  out  FIFO head is valid
//   out_ready  in   consumer takes the head when out_valid && out_ready
//   out_r/g/b  out  8 each expanded colour of the head pixel
//   out_sof    out  head pixel is the first pixel of a frame
//   fifo_lvl   out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//   ovf        out  sticky: a pixel was dropped because the FIFO was full
//   sync_err   out  sticky: a sof beat cut a partially assembled pixel
//   drop_cnt   out  16  dropped-pixel count, saturating (only with
//                       SDIO_PIXASM_DROPCNT_EN defined)
//
// Build option:
//   SDIO_PIXASM_DROPCNT_EN  adds the drop_cnt port and its counter.
// -----------------------------------------------------------------------------
module sdio_pixel_assembler
    import sdio_pixel_assembler_pkg::*;
#(
    parameter int BUS_W      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_pix,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [BUS_W-1:0]              in_data,
    input  logic                          in_sof,
    input  logic                          fmt_888,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_r,
    output logic [7:0]                    out_g,
    output logic [7:0]                    out_b,
    output logic                          out_sof,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl,
    output logic                          ovf,
    output logic                          sync_err
`ifdef SDIO_PIXASM_DROPCNT_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    // The shift register keeps the previous beats; together with the beat on
    // in_data it forms the full 24-bit window, so the completing beat can be
    // written straight into the FIFO on its own edge.
    localparam int SR_W  = PIX888_W - BUS_W;
    localparam int CNT_W = $clog2(PIX888_W / BUS_W) + 1;

    localparam logic [CNT_W-1:0] LAST_565 = CNT_W'(PIX565_W / BUS_W - 1);
    localparam logic [CNT_W-1:0] LAST_888 = CNT_W'(PIX888_W / BUS_W - 1);

    // Assembly state
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic                fmt_q, fmt_d;
    logic                sof_pend_q, sof_pend_d;
    logic                sync_err_q, sync_err_d;
    logic                ovf_q, ovf_d;

    logic [PIX888_W-1:0] pix_now;
    logic [CNT_W-1:0]    last_beat;
    logic                push;
    logic                drop;
    rgb_entry_t          wr_entry;
    rgb_entry_t          rd_entry;

    // FIFO interface
    logic [RGB_ENTRY_W-1:0] fifo_wdata;
    logic [RGB_ENTRY_W-1:0] fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LVL_W-1:0]       fifo_level;

    assign pix_now   = {sr_q, in_data};
    assign last_beat = (fmt_q == FMT_888) ? LAST_888 : LAST_565;

    // ------------------------------------------------------------------
    // Beat counter, format latch and sof tag
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        fmt_d      = fmt_q;
        sof_pend_d = sof_pend_q;
        sync_err_d = sync_err_q;
        push       = 1'b0;
        sr_d       = sr_q;

        if (in_valid) begin
            sr_d = pix_now[SR_W-1:0];
            if (in_sof) begin
                // A sof beat always restarts assembly as beat 0 with the new
                // format. Every format has at least two beats, so this beat
                // can never also complete a pixel.
                fmt_d      = fmt_888;
                sof_pend_d = 1'b1;
                cnt_d      = CNT_W'(1);
                if (cnt_q != '0) begin
                    sync_err_d = 1'b1;
                end
            end else if (cnt_q == last_beat) begin
                push       = 1'b1;
                cnt_d      = '0;
                sof_pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Expansion into a FIFO entry
    // ------------------------------------------------------------------
    always_comb begin
        wr_entry     = '0;
        wr_entry.sof = sof_pend_q;
        if (fmt_q == FMT_888) begin
            {wr_entry.r, wr_entry.g, wr_entry.b} = pix_now;
        end else begin
            {wr_entry.r, wr_entry.g, wr_entry.b} = rgb565_to_888(pix_now[PIX565_W-1:0]);
        end
    end

    assign fifo_wdata = wr_entry;

    // Full implies non-empty, so out_ready alone decides whether the head
    // leaves on this edge and makes room for the new pixel.
    assign drop  = push && fifo_full && !out_ready;
    assign ovf_d = ovf_q || drop;

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            fmt_q      <= FMT_565;
            sof_pend_q <= 1'b0;
            sync_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            fmt_q      <= fmt_d;
            sof_pend_q <= sof_pend_d;
            sync_err_q <= sync_err_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SDIO_PIXASM_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (RGB_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_pix),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (out_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Outputs come only from FIFO pointers/storage and the sticky registers.
    assign rd_entry  = rgb_entry_t'(fifo_rdata);
    assign out_valid = !fifo_empty;
    assign out_sof   = rd_entry.sof;
    assign out_r     = rd_entry.r;
    assign out_g     = rd_entry.g;
    assign out_b     = rd_entry.b;
    assign fifo_lvl  = fifo_level;
    assign ovf       = ovf_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_sdio_pixel_assembler.sv
module tb_sdio_pixel_assembler;

    localparam int BUS_W = 4;
    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk_pix;
    logic             rst_n;
    logic             in_valid;
    logic [BUS_W-1:0] in_data;
    logic             in_sof;
    logic             fmt_888;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_r;
    logic [7:0]       out_g;
    logic [7:0]       out_b;
    logic             out_sof;
    logic [LVL_W-1:0] fifo_lvl;
    logic             ovf;
    logic             sync_err;
`ifdef SDIO_PIXASM_DROPCNT_EN
    logic [15:0]      drop_cnt;
`endif

    sdio_pixel_assembler #(
        .BUS_W      (BUS_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .fmt_888   (fmt_888),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .out_sof   (out_sof),
        .fifo_lvl  (fifo_lvl),
        .ovf       (ovf),
        .sync_err  (sync_err)
`ifdef SDIO_PIXASM_DROPCNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of expected {sof, r, g, b} entries, in acceptance order.
    logic [24:0] sb[$];

    // Reference model state
    int          mlvl;
    bit          movf;
    bit          mserr;
    int          mdcnt;
    bit          mfmt;
    bit          mtag;
    int          mn;
    int unsigned macc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] expand(input bit tag, input int unsigned p, input bit is888);
        int unsigned r, g, b;
        if (is888) begin
            r = (p >> 16) & 255;
            g = (p >> 8) & 255;
            b = p & 255;
        end else begin
            r = (p >> 11) & 31;
            g = (p >> 5) & 63;
            b = p & 31;
            r = r * 8 + r / 4;
            g = g * 4 + g / 16;
            b = b * 8 + b / 4;
        end
        return {tag, r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic check_state();
        chk("fifo_lvl", 32'(fifo_lvl), 32'(mlvl));
        chk("out_valid", 32'(out_valid), 32'(mlvl != 0));
        chk("ovf", 32'(ovf), 32'(movf));
        chk("sync_err", 32'(sync_err), 32'(mserr));
`ifdef SDIO_PIXASM_DROPCNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(mdcnt));
`endif
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({out_sof, out_r, out_g, out_b}), 32'd0);
        chk("rst_fifo_lvl", 32'(fifo_lvl), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
`ifdef SDIO_PIXASM_DROPCNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    endtask

    task automatic check_head(input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input bit s);
        chk("head_valid", 32'(out_valid), 32'd1);
        chk("head_pixel", 32'({out_sof, out_r, out_g, out_b}), 32'({s, r, g, b}));
    endtask

    // One clock cycle: called 1 time unit after a rising edge. Checks the
    // state left by the previous edge, drives this cycle's inputs and
    // advances the model to what the next edge must produce.
    task automatic cycle(input bit v, input logic [BUS_W-1:0] d, input bit s,
                         input bit f, input bit rdy);
        bit          pop;
        bit          done;
        logic [24:0] e;
        check_state();
        in_valid  = v;
        in_data   = d;
        in_sof    = s;
        fmt_888   = f;
        out_ready = rdy;
        pop  = rdy && (mlvl > 0);
        done = 1'b0;
        e    = '0;
        if (v) begin
            if (s) begin
                if (mn != 0) mserr = 1'b1;
                mfmt = f;
                mtag = 1'b1;
                macc = 32'(d);
                mn   = 1;
            end else begin
                macc = (macc << BUS_W) | 32'(d);
                mn   = mn + 1;
            end
            if (mn == (mfmt ? 24 : 16) / BUS_W) begin
                e    = expand(mtag, macc, mfmt);
                done = 1'b1;
                mtag = 1'b0;
                mn   = 0;
                macc = 0;
            end
        end
        if (done) begin
            if (mlvl < DEPTH || pop) begin
                sb.push_back(e);
                mlvl = mlvl + 1;
            end else begin
                movf = 1'b1;
                if (mdcnt != 16'hFFFF) mdcnt = mdcnt + 1;
            end
        end
        if (pop) mlvl = mlvl - 1;
        @(posedge clk_pix);
        #1;
    endtask

    task automatic do_reset(input bit beat_during);
        rst_n     = 1'b0;
        in_valid  = beat_during;
        in_data   = BUS_W'($urandom);
        in_sof    = 1'($urandom);
        fmt_888   = 1'($urandom);
        out_ready = 1'($urandom);
        sb.delete();
        mlvl  = 0;
        movf  = 1'b0;
        mserr = 1'b0;
        mdcnt = 0;
        mfmt  = 1'b0;
        mtag  = 1'b0;
        mn    = 0;
        macc  = 0;
        @(posedge clk_pix);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic send_pix(input logic [23:0] p, input bit is888, input bit s, input bit rdy_last);
        int          nb;
        logic [23:0] sh;
        nb = (is888 ? 24 : 16) / BUS_W;
        for (int i = 0; i < nb; i++) begin
            sh = p >> ((nb - 1 - i) * BUS_W);
            cycle(1'b1, sh[BUS_W-1:0], s && (i == 0), is888, (i == nb - 1) ? rdy_last : 1'b0);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (mlvl > 0 && k < 4 * DEPTH) begin
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            k++;
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: samples mid-cycle; a handshake seen here completes on the
    // following rising edge, so the head is compared against the scoreboard.
    initial begin
        logic [24:0] cur;
        logic [24:0] prev;
        logic [24:0] e;
        bit          prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk_pix);
            cur = {out_sof, out_r, out_g, out_b};
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(cur), 32'(prev));
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_pixel actual=%0h required=none t=%0t", cur, $time);
                    end else begin
                        e = sb.pop_front();
                        $display("pixel sof=%0d r=%02h g=%02h b=%02h (expect %07h)",
                                 out_sof, out_r, out_g, out_b, e);
                        chk("pixel", 32'(cur), 32'(e));
                    end
                end
                prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
                prev       = cur;
            end
        end
    end

    initial begin
        int rdy_pct[4];
        rdy_pct[0] = 10;
        rdy_pct[1] = 50;
        rdy_pct[2] = 90;
        rdy_pct[3] = 30;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        fmt_888   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk_pix);
        #1;
        do_reset(1'b0);
        check_reset_outputs();

        // 565 pixel F800 starting a frame
        cycle(1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("t1_not_early", 32'(out_valid), 32'd0);
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        check_head(8'hFF, 8'h00, 8'h00, 1'b1);
        drain();

        // 888 pixel 123456, then format toggling mid-frame is ignored
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, BUS_W'(i), i == 1, 1'b1, 1'b0);
        end
        check_head(8'h12, 8'h34, 8'h56, 1'b1);
        drain();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, BUS_W'(10 + i), 1'b0, 1'(i), 1'b0);
        end
        check_head(8'hAB, 8'hCD, 8'hEF, 1'b0);
        drain();

        // Overflow: 17 pixels into a 16-deep FIFO with no consumer
        do_reset(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_pix(24'($urandom), 1'b0, i == 0, 1'b0);
        end
        chk("t3_lvl_full", 32'(fifo_lvl), 32'(DEPTH));
        chk("t3_ovf", 32'(ovf), 32'd1);
`ifdef SDIO_PIXASM_DROPCNT_EN
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        drain();

        // Full FIFO, pop on the same edge as the completing beat
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send_pix(24'($urandom), 1'b0, 1'b0, 1'b0);
        end
        send_pix(24'($urandom), 1'b0, 1'b0, 1'b1);
        chk("t4_lvl_full", 32'(fifo_lvl), 32'(DEPTH));
        chk("t4_no_ovf", 32'(ovf), 32'd0);
        drain();

        // Sof cutting a partial pixel
        cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_sync_err", 32'(sync_err), 32'd1);
        cycle(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        check_head(8'h00, 8'hFF, 8'h00, 1'b1);
        drain();

        // Reset mid-pixel with entries queued, beat presented during reset
        for (int i = 0; i < 3; i++) begin
            send_pix(24'($urandom), 1'b0, 1'b0, 1'b0);
        end
        cycle(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        check_reset_outputs();
        cycle(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        check_head(8'h10, 8'h45, 8'hA5, 1'b0);
        drain();

        // Randomised traffic in phases of different consumer throughput
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(399) == 0) begin
                    do_reset(1'($urandom));
                end else begin
                    cycle($urandom_range(9) < 7, BUS_W'($urandom), $urandom_range(15) == 0,
                          1'($urandom), $urandom_range(99) < rdy_pct[ph]);
                end
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
